// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM encoding and
// the fixed instruction encodings the fetch stage recognises.
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam int unsigned INSTR_BYTES  = 32'd4;

endpackage : riscv_pkg

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch stage: ROM port, execute redirect and the
// IF/ID handshake toward decode. master = fetch side, slave = environment.
interface fetch_unit_if #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PC_WIDTH      = 32
);

  logic [ADDRESS_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0]    rom_instr;
  logic                     redirect_valid;
  logic [PC_WIDTH-1:0]      redirect_target;
  logic                     id_valid;
  logic                     id_ready;
  logic [DATA_WIDTH-1:0]    id_instr;
  logic [PC_WIDTH-1:0]      id_pc;
  logic [PC_WIDTH-1:0]      id_pc_plus4;
  logic                     halted;

  modport master (
    output rom_addr,
    input  rom_instr,
    input  redirect_valid,
    input  redirect_target,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output halted
  );

  modport slave (
    input  rom_addr,
    output rom_instr,
    output redirect_valid,
    output redirect_target,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  halted
  );

endinterface : fetch_unit_if

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with valid/ready toward decode. Flush beats load,
// and a consumed entry drops valid unless a new one is loaded that cycle.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic [PC_WIDTH-1:0]   pc_plus4_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic [PC_WIDTH-1:0]   pc_plus4_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pc_plus4_q, pc_plus4_d;

  // Next contents of the IF/ID register.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // IF/ID storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= DATA_WIDTH'(NOP_INSTR);
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule : if_id_reg

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALT control, redirect handling and
// the IF/ID register feeding decode. ROM is read asynchronously by word.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned         ADDRESS_WIDTH = 5,
  parameter int unsigned         DATA_WIDTH    = 32,
  parameter int unsigned         PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = PC_WIDTH'(32'h0000_0000)
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  // Clears the byte-offset bits so the PC always stays word aligned.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INSTR_BYTES - 32'd1);

  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                halted_q, halted_d;
  logic [PC_WIDTH-1:0] pc_plus4_s;
  logic [PC_WIDTH-1:0] redirect_pc_s;
  logic                id_valid_s;
  logic                adv_s;
  logic                is_ebreak_s;
  logic                load_s;
  logic                flush_s;

  assign pc_plus4_s    = pc_q + PC_WIDTH'(INSTR_BYTES);
  assign redirect_pc_s = bus.redirect_target & ALIGN_MASK;
  assign adv_s         = !id_valid_s || bus.id_ready;
  assign is_ebreak_s   = (bus.rom_instr == DATA_WIDTH'(EBREAK_INSTR));
  assign bus.rom_addr  = pc_q[ADDRESS_WIDTH+1:2];

  // State, PC and halt flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC & ALIGN_MASK;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic; a redirect cancels an EBREAK fetched in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.redirect_valid && adv_s && is_ebreak_s) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // PC update and IF/ID load/flush controls per state.
  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    load_s   = 1'b0;
    flush_s  = 1'b0;
    case (state_q)
      BOOT: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_pc_s;
          flush_s = 1'b1;
        end else begin
          pc_d = pc_q;
        end
      end
      RUN: begin
        if (bus.redirect_valid) begin
          pc_d    = redirect_pc_s;
          flush_s = 1'b1;
        end else if (adv_s) begin
          pc_d     = pc_plus4_s;
          load_s   = 1'b1;
          halted_d = halted_q | is_ebreak_s;
        end else begin
          pc_d = pc_q;
        end
      end
      HALT: begin
        pc_d     = pc_q;
        halted_d = 1'b1;
      end
      default: begin
        pc_d     = pc_q;
        halted_d = halted_q;
      end
    endcase
  end

  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_s),
    .flush_i    (flush_s),
    .ready_i    (bus.id_ready),
    .instr_i    (bus.rom_instr),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4_s),
    .valid_o    (id_valid_s),
    .instr_o    (bus.id_instr),
    .pc_o       (bus.id_pc),
    .pc_plus4_o (bus.id_pc_plus4)
  );

  assign bus.id_valid = id_valid_s;
  assign bus.halted   = halted_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instructions are queued per
// scenario and checked by a monitor at each accepted IF/ID handshake.
module tb_fetch_unit;
  import riscv_pkg::*;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] rom [0:31];
  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_instr = rom[bus.rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_q.push_back({instr, pc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    tick();
    tick();
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_instr", bus.id_instr, 32'h0000_0013);
    chk("rst_id_pc", bus.id_pc, 32'd0);
    chk("rst_id_pc_plus4", bus.id_pc_plus4, 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: an entry is consumed when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got pc %h instr %h, required no output", bus.id_pc, bus.id_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.id_instr, bus.id_pc, bus.id_pc_plus4} !== {mon_e.instr, mon_e.pc, mon_e.pc + 32'd4}) begin
          n_bad++;
          $display("FAIL sb_handshake: got instr %h pc %h pc4 %h, required instr %h pc %h pc4 %h",
                   bus.id_instr, bus.id_pc, bus.id_pc_plus4, mon_e.instr, mon_e.pc, mon_e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active, required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0013;
    rom[0] = 32'h0ff0_0313;
    rom[1] = 32'h0000_0513;
    rom[2] = 32'h00a0_0593;
    rom[3] = 32'h00c0_0693;
    rom[4] = 32'h00d0_0713;
    rom[5] = 32'h00e0_0793;

    // Scenario 1: boot, stream, backpressure, redirect at pc=0x10
    push(32'h0ff0_0313, 32'h00);
    push(32'h0000_0513, 32'h04);
    push(32'h00a0_0593, 32'h08);
    push(32'h00d0_0713, 32'h10);
    do_reset();
    bus.id_ready = 1'b1;
    tick();
    chk("boot_id_valid", 32'(bus.id_valid), 32'd0);
    chk("boot_rom_addr", 32'(bus.rom_addr), 32'd0);
    tick();
    chk("first_valid", 32'(bus.id_valid), 32'd1);
    chk("first_pc", bus.id_pc, 32'h0);
    tick();
    chk("second_pc", bus.id_pc, 32'h4);
    bus.id_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_valid", 32'(bus.id_valid), 32'd1);
      chk("stall_pc", bus.id_pc, 32'h4);
      chk("stall_instr", bus.id_instr, 32'h0000_0513);
      chk("stall_rom_addr", 32'(bus.rom_addr), 32'd2);
    end
    bus.id_ready = 1'b1;
    tick();
    chk("resume_pc", bus.id_pc, 32'h8);
    tick();
    chk("pc_c", bus.id_pc, 32'hC);
    chk("pc10_rom_addr", 32'(bus.rom_addr), 32'd4);
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0000_0012;
    tick();
    chk("redir_flush_valid", 32'(bus.id_valid), 32'd0);
    chk("redir_rom_addr", 32'(bus.rom_addr), 32'd4);
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    tick();
    chk("redir_target_valid", 32'(bus.id_valid), 32'd1);
    chk("redir_target_pc", bus.id_pc, 32'h10);
    chk("redir_target_instr", bus.id_instr, 32'h00d0_0713);
    tick();
    bus.id_ready = 1'b0;

    // Scenario 2: redirect coinciding with EBREAK, then a real halt
    rom[3] = 32'h0010_0073;
    push(32'h0ff0_0313, 32'h00);
    push(32'h0ff0_0313, 32'h00);
    push(32'h0000_0513, 32'h04);
    push(32'h00a0_0593, 32'h08);
    push(32'h0010_0073, 32'h0C);
    do_reset();
    bus.id_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0000_000C;
    tick();
    chk("toC_valid", 32'(bus.id_valid), 32'd0);
    chk("toC_rom_addr", 32'(bus.rom_addr), 32'd3);
    bus.redirect_target = 32'h0;
    tick();
    chk("ebrk_redir_valid", 32'(bus.id_valid), 32'd0);
    chk("ebrk_redir_halted", 32'(bus.halted), 32'd0);
    chk("ebrk_redir_rom_addr", 32'(bus.rom_addr), 32'd0);
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    tick();
    chk("after_redir_pc", bus.id_pc, 32'h0);
    tick();
    tick();
    tick();
    chk("ebreak_instr", bus.id_instr, 32'h0010_0073);
    chk("ebreak_pc", bus.id_pc, 32'hC);
    tick();
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_valid", 32'(bus.id_valid), 32'd0);
    chk("halt_rom_addr", 32'(bus.rom_addr), 32'd4);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0;
    tick();
    chk("halt_redir_rom_addr", 32'(bus.rom_addr), 32'd4);
    chk("halt_redir_halted", 32'(bus.halted), 32'd1);
    chk("halt_redir_valid", 32'(bus.id_valid), 32'd0);
    bus.redirect_valid = 1'b0;
    tick();

    // Scenario 3: async reset while EBREAK is held under backpressure
    push(32'h0ff0_0313, 32'h00);
    push(32'h0000_0513, 32'h04);
    push(32'h00a0_0593, 32'h08);
    do_reset();
    bus.id_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    bus.id_ready = 1'b0;
    tick();
    chk("hold_halted", 32'(bus.halted), 32'd1);
    chk("hold_valid", 32'(bus.id_valid), 32'd1);
    chk("hold_pc", bus.id_pc, 32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.id_valid), 32'd0);
    chk("arst_halted", 32'(bus.halted), 32'd0);
    chk("arst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("arst_instr", bus.id_instr, 32'h0000_0013);
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fetch_unit
